// File: rtl/hazard_control_unit.sv
// Hazard controller for the 5-stage RV32I pipeline: load-use bubbles, branch flushes, memory-wait freeze, watchdog.
// Optional performance counters are compiled in with HAZARD_PERF_COUNTERS_EN.
module hazard_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] rs1_if_id_i,
  input  logic [4:0] rs2_if_id_i,
  input  logic       uses_rs1_if_id_en,
  input  logic       uses_rs2_if_id_en,
  input  logic [4:0] rd_id_ex_i,
  input  logic       mem_read_id_ex_en,
  input  logic       branch_taken_ex_en,
  input  logic       dmem_busy_en,
  output logic       pc_stall_o,
  output logic       if_id_stall_o,
  output logic       if_id_flush_o,
  output logic       id_ex_stall_o,
  output logic       id_ex_flush_o,
  output logic       ex_mem_stall_o,
  output logic       mem_wb_stall_o,
  output logic       fault_o
`ifdef HAZARD_PERF_COUNTERS_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_cycles_o,
  output logic [CNT_WIDTH-1:0] flush_count_o,
  output logic [CNT_WIDTH-1:0] load_use_count_o
`endif
);

  localparam int unsigned WD_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_e;

  state_e            state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              fault_q;
  logic              lu;
  logic              lu_sel;

  assign lu = mem_read_id_ex_en && (rd_id_ex_i != 5'd0) &&
              (((rd_id_ex_i == rs1_if_id_i) && uses_rs1_if_id_en) ||
               ((rd_id_ex_i == rs2_if_id_i) && uses_rs2_if_id_en));

  // State, watchdog and sticky fault registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      wd_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      fault_q <= fault_q | (state_q == FAULT);
    end
  end

  assign fault_o = fault_q;

  // Next state and hazard outputs
  always_comb begin
    state_d        = state_q;
    wd_d           = wd_q;
    lu_sel         = 1'b0;
    pc_stall_o     = 1'b0;
    if_id_stall_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_stall_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_stall_o = 1'b0;
    mem_wb_stall_o = 1'b0;
    if ((state_q == FAULT) || dmem_busy_en) begin
      pc_stall_o     = 1'b1;
      if_id_stall_o  = 1'b1;
      id_ex_stall_o  = 1'b1;
      ex_mem_stall_o = 1'b1;
      mem_wb_stall_o = 1'b1;
    end else if (branch_taken_ex_en) begin
      if_id_flush_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
    end else if (lu) begin
      pc_stall_o     = 1'b1;
      if_id_stall_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
      lu_sel         = 1'b1;
    end
    case (state_q)
      RUN: begin
        if (dmem_busy_en) begin
          state_d = MEM_WAIT;
          wd_d    = WD_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!dmem_busy_en) begin
          state_d = RUN;
          wd_d    = '0;
        end else if (wd_q == WD_W'(MEM_TIMEOUT)) begin
          state_d = FAULT;
        end else begin
          wd_d    = wd_q + WD_W'(1);
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = RUN;
    endcase
  end

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [CNT_WIDTH-1:0] stall_q, flush_q, lu_cnt_q;

  // Saturating performance counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q  <= '0;
      flush_q  <= '0;
      lu_cnt_q <= '0;
    end else begin
      if (pc_stall_o && (stall_q != '1))    stall_q  <= stall_q + CNT_WIDTH'(1);
      if (if_id_flush_o && (flush_q != '1)) flush_q  <= flush_q + CNT_WIDTH'(1);
      if (lu_sel && (lu_cnt_q != '1))       lu_cnt_q <= lu_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign stall_cycles_o   = stall_q;
  assign flush_count_o    = flush_q;
  assign load_use_count_o = lu_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit (MEM_TIMEOUT=4): driver queues expectations, negedge monitor checks.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       u1 = 1'b0, u2 = 1'b0, mr = 1'b0, br = 1'b0, busy = 1'b0;
  logic pc_st, ifid_st, ifid_fl, idex_st, idex_fl, exmem_st, memwb_st, fault;
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] st_cnt, fl_cnt, lu_cnt;
`endif

  hazard_control_unit #(.MEM_TIMEOUT(4), .CNT_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .rs1_if_id_i(rs1), .rs2_if_id_i(rs2),
    .uses_rs1_if_id_en(u1), .uses_rs2_if_id_en(u2),
    .rd_id_ex_i(rd), .mem_read_id_ex_en(mr),
    .branch_taken_ex_en(br), .dmem_busy_en(busy),
    .pc_stall_o(pc_st), .if_id_stall_o(ifid_st), .if_id_flush_o(ifid_fl),
    .id_ex_stall_o(idex_st), .id_ex_flush_o(idex_fl),
    .ex_mem_stall_o(exmem_st), .mem_wb_stall_o(memwb_st),
    .fault_o(fault)
`ifdef HAZARD_PERF_COUNTERS_EN
    , .stall_cycles_o(st_cnt), .flush_count_o(fl_cnt), .load_use_count_o(lu_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Output bit order: pc, if_id stall, if_id flush, id_ex stall, id_ex flush, ex_mem, mem_wb, fault
  localparam logic [7:0] NONE  = 8'h00;
  localparam logic [7:0] STALL = 8'hD6;
  localparam logic [7:0] FLUSH = 8'h28;
  localparam logic [7:0] LUB   = 8'hC8;
  localparam logic [7:0] FLT   = 8'hD7;

  logic [7:0] exp_q[$];
  string      name_q[$];
  int         cnt_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         m_st = 0, m_fl = 0, m_lu = 0;

  wire [7:0] act = {pc_st, ifid_st, ifid_fl, idex_st, idex_fl, exmem_st, memwb_st, fault};

  task automatic step(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                      input logic e1, input logic e2, input logic [4:0] d,
                      input logic m, input logic b, input logic bz,
                      input logic [7:0] e, input logic is_lu, input string nm);
    @(posedge clk);
    #1;
    rst = r; rs1 = a1; rs2 = a2; u1 = e1; u2 = e2; rd = d; mr = m; br = b; busy = bz;
    exp_q.push_back(e);
    name_q.push_back(nm);
    if (r) begin
      m_st = 0; m_fl = 0; m_lu = 0;
    end
    cnt_q.push_back(m_st); cnt_q.push_back(m_fl); cnt_q.push_back(m_lu);
    if (!r) begin
      m_st += int'(e[7]);
      m_fl += int'(e[5]);
      m_lu += int'(is_lu);
    end
  endtask

  // Monitor: one expectation per driven cycle, checked mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [7:0] e;
      string nm;
      int cs, cf, cl;
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      cs = cnt_q.pop_front(); cf = cnt_q.pop_front(); cl = cnt_q.pop_front();
      n_cmp++;
      if (act !== e) begin
        n_err++;
        $display("FAIL %s: outputs got %b want %b", nm, act, e);
      end
`ifdef HAZARD_PERF_COUNTERS_EN
      n_cmp++;
      if (st_cnt !== 32'(cs) || fl_cnt !== 32'(cf) || lu_cnt !== 32'(cl)) begin
        n_err++;
        $display("FAIL %s counters: got %0d/%0d/%0d want %0d/%0d/%0d",
                 nm, st_cnt, fl_cnt, lu_cnt, cs, cf, cl);
      end
`endif
    end
  end

  initial begin
    //    rst rs1    rs2    u1    u2    rd     mr    br    busy  expect lu
    step(1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NONE,  1'b0, "reset");
    step(0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NONE,  1'b0, "idle");
    step(0, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, LUB,   1'b1, "lu_rs2");
    step(0, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, NONE,  1'b0, "bubble");
    step(0, 5'd0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, NONE,  1'b0, "lu_x0");
    step(0, 5'd7, 5'd3, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, NONE,  1'b0, "lu_unused");
    step(0, 5'd7, 5'd3, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, LUB,   1'b1, "lu_rs1");
    step(0, 5'd7, 5'd3, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, FLUSH, 1'b0, "br_over_lu");
    step(0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, STALL, 1'b0, "wait1");
    step(0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, STALL, 1'b0, "wait2");
    step(0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, STALL, 1'b0, "wait3");
    step(0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FLUSH, 1'b0, "wait_exit_br");
    step(0, 5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, LUB,   1'b1, "lu_after_wait");
    step(0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NONE,  1'b0, "run_idle");
    // Four busy cycles stay below the timeout
    for (int i = 0; i < 4; i++)
      step(0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, STALL, 1'b0, "busy4");
    step(0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NONE,  1'b0, "no_fault_at_4");
    // Five busy cycles trip the watchdog
    for (int i = 0; i < 5; i++)
      step(0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, STALL, 1'b0, "busy5");
    step(0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, STALL, 1'b0, "fault_entry");
    step(0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FLT,   1'b0, "fault_br");
    step(0, 5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, FLT,   1'b0, "fault_lu");
    step(0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, FLT,   1'b0, "fault_sticky");
    step(1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NONE,  1'b0, "fault_reset");
    step(0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NONE,  1'b0, "post_reset");
    step(0, 5'd0, 5'd2, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, LUB,   1'b1, "post_reset_lu");
    step(0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, STALL, 1'b0, "post_reset_busy");
    step(0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NONE,  1'b0, "final");
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
